mem_uart_reader: RTL and testbench

Read-back engine for the single-port test memories: on command it walks an address range of a `mem_single` instance, splits each WIDTH-bit word into bytes and streams them through the UART `Transmitter`. It sits beside the UART receive/write path in the FPGA test wrappers, so the host can dump memory contents (keys, ciphertexts, error vectors) after a run.

---
 rtl/mem_uart_reader_if.sv | 28 ++
 rtl/mem_uart_reader.sv | 162 ++++++++++++++++
 tb/tb_mem_uart_reader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_uart_reader_if.sv
// Memory read port and UART transmitter handshake between mem_uart_reader and its surroundings.
// The reader drives the address and byte strobe; memory and Transmitter return data and completion.
interface mem_uart_reader_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    logic [DEPTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_q;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_done;

    modport master (
        output mem_addr,
        output tx_start,
        output tx_data,
        input  mem_q,
        input  tx_done
    );

    modport slave (
        input  mem_addr,
        input  tx_start,
        input  tx_data,
        output mem_q,
        output tx_done
    );
endinterface

// File: rtl/mem_uart_reader.sv
// Walks a word range of a registered-read memory and streams each word LSB-first to the UART Transmitter.
// Define MEM_UART_READER_CHECKSUM_EN to append an XOR checksum byte after the last word.
module mem_uart_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DEPTH-1:0]       first_addr,
    input  logic [DEPTH-1:0]       last_addr,
    mem_uart_reader_if.master      bus,
    output logic                   busy,
    output logic                   done
);
    localparam int NB    = WIDTH / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, FETCH, LOAD, SEND, WAIT_TX, NEXT
    } state_t;

    state_t           state, state_nx;
    logic [DEPTH-1:0] addr_q, addr_nx;
    logic [DEPTH-1:0] last_q, last_nx;
    logic [WIDTH-1:0] shift_q, shift_nx;
    logic [IDX_W-1:0] idx_q, idx_nx;
    logic [7:0]       tx_data_q, tx_data_nx;
    logic             tx_start_q, tx_start_nx;
    logic             busy_nx, done_nx;
    logic             more_bytes, last_word;
`ifdef MEM_UART_READER_CHECKSUM_EN
    logic [7:0]       chk_q, chk_nx;
    logic             chk_phase_q, chk_phase_nx;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef MEM_UART_READER_CHECKSUM_EN
            chk_q       <= '0;
            chk_phase_q <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            addr_q     <= addr_nx;
            last_q     <= last_nx;
            shift_q    <= shift_nx;
            idx_q      <= idx_nx;
            tx_data_q  <= tx_data_nx;
            tx_start_q <= tx_start_nx;
            busy       <= busy_nx;
            done       <= done_nx;
`ifdef MEM_UART_READER_CHECKSUM_EN
            chk_q       <= chk_nx;
            chk_phase_q <= chk_phase_nx;
`endif
        end
    end

    // The checksum byte behaves as a one-byte word that ends the dump.
    always_comb begin
`ifdef MEM_UART_READER_CHECKSUM_EN
        more_bytes = !chk_phase_q && (idx_q != LAST_IDX);
        last_word  = chk_phase_q;
`else
        more_bytes = (idx_q != LAST_IDX);
        last_word  = (addr_q == last_q);
`endif
    end

    always_comb begin
        state_nx   = state;
        addr_nx    = addr_q;
        last_nx    = last_q;
        shift_nx   = shift_q;
        idx_nx     = idx_q;
        tx_data_nx = tx_data_q;
        done_nx    = 1'b0;
`ifdef MEM_UART_READER_CHECKSUM_EN
        chk_nx       = chk_q;
        chk_phase_nx = chk_phase_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ADDR;
                    addr_nx  = first_addr;
                    last_nx  = last_addr;
                    idx_nx   = '0;
`ifdef MEM_UART_READER_CHECKSUM_EN
                    chk_nx       = '0;
                    chk_phase_nx = 1'b0;
`endif
                end
            end
            ADDR:  state_nx = FETCH;
            FETCH: state_nx = LOAD;
            LOAD: begin
                shift_nx = bus.mem_q;
                idx_nx   = '0;
                state_nx = SEND;
            end
            SEND: state_nx = WAIT_TX;
            WAIT_TX: begin
                if (bus.tx_done) begin
                    if (more_bytes) begin
                        shift_nx = shift_q >> 8;
                        idx_nx   = idx_q + IDX_W'(1);
                        state_nx = SEND;
                    end else begin
                        state_nx = NEXT;
                        done_nx  = last_word;
                    end
                end
            end
            NEXT: begin
                // done was raised on entry to NEXT when this was the final byte.
                if (done) begin
                    state_nx = IDLE;
`ifdef MEM_UART_READER_CHECKSUM_EN
                end else if (addr_q == last_q) begin
                    chk_phase_nx = 1'b1;
                    state_nx     = SEND;
`endif
                end else begin
                    addr_nx  = addr_q + DEPTH'(1);
                    state_nx = ADDR;
                end
            end
            default: state_nx = IDLE;
        endcase

        tx_start_nx = (state_nx == SEND);
        if (state_nx == SEND) begin
`ifdef MEM_UART_READER_CHECKSUM_EN
            if (chk_phase_nx) begin
                tx_data_nx = chk_q;
            end else begin
                tx_data_nx = shift_nx[7:0];
                chk_nx     = chk_q ^ shift_nx[7:0];
            end
`else
            tx_data_nx = shift_nx[7:0];
`endif
        end
        busy_nx = (state_nx != IDLE);
    end

    assign bus.mem_addr = addr_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_mem_uart_reader.sv
// Randomized bench for mem_uart_reader: memory/Transmitter responder plus a byte-stream scoreboard.
module tb_mem_uart_reader;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int NB    = WIDTH / 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [DEPTH-1:0] first_addr;
    logic [DEPTH-1:0] last_addr;
    logic             busy;
    logic             done;

    mem_uart_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    mem_uart_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [256];
    int n_cmp = 0;
    int n_bad = 0;
    int tx_delay = 1;
    int spur_req = 0;
    int spur_ack = 0;
    int tx_cnt = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Registered-read memory and a Transmitter that answers tx_start after tx_delay cycles.
    initial begin : responder
        logic [DEPTH-1:0] a;
        logic ts;
        bus.mem_q   = '0;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            a  = bus.mem_addr;
            ts = bus.tx_start;
            @(posedge clk);
            #1;
            bus.mem_q   = mem[a];
            bus.tx_done = 1'b0;
            if (!reset) begin
                tx_cnt = 0;
            end else begin
                if (ts) tx_cnt = tx_delay;
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) bus.tx_done = 1'b1;
                end
                if (spur_req != spur_ack) begin
                    spur_ack++;
                    bus.tx_done = 1'b1;
                end
            end
        end
    end

    task automatic run_dump(input logic [7:0] f, input logic [7:0] l, input int dly,
                            input bit spur, input bit busy_start, input bit end_start);
        logic [7:0] eb[$];
        logic [7:0] ea[$];
        int         eg[$];
        logic [WIDTH-1:0] w;
        logic [7:0] held;
        int nw, cyc, last_done, budget, nsent, total, extra;
        bit pending, done_seen, unstable;
`ifdef MEM_UART_READER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        nw = ((int'(l) - int'(f) + 256) % 256) + 1;
        for (int i = 0; i < nw; i++) begin
            logic [7:0] a;
            a = 8'(int'(f) + i);
            w = mem[a];
            for (int b = 0; b < NB; b++) begin
                eb.push_back(w[8*b +: 8]);
                ea.push_back(a);
                eg.push_back(b > 0 ? 1 : (i == 0 ? 4 : 5));
`ifdef MEM_UART_READER_CHECKSUM_EN
                x = x ^ w[8*b +: 8];
`endif
            end
        end
`ifdef MEM_UART_READER_CHECKSUM_EN
        eb.push_back(x);
        ea.push_back(l);
        eg.push_back(2);
`endif
        total  = eb.size();
        budget = total * (dly + 8) + 40;
        tx_delay = dly;
        start = 1'b1;
        first_addr = f;
        last_addr  = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        first_addr = 8'($urandom);
        last_addr  = 8'($urandom);
        cyc = 0; last_done = 0; nsent = 0; extra = 0;
        pending = 0; done_seen = 0; unstable = 0; held = 8'h00;
        while (!done_seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                chk_eq("busy_rise", busy, 1);
                if (spur) spur_req++;
            end
            if (busy_start && cyc == 8) begin
                start = 1'b1;
                first_addr = 8'd5;
                last_addr  = 8'd5;
            end
            if (bus.tx_start) begin
                chk_eq("tx_overlap", pending, 0);
                if (eb.size() > 0) begin
                    chk_eq("byte_gap", (nsent == 0) ? cyc : cyc - last_done, eg.pop_front());
                    chk_eq("tx_data", bus.tx_data, eb.pop_front());
                    chk_eq("mem_addr", bus.mem_addr, ea.pop_front());
                end
                nsent++;
                pending = 1;
                held = bus.tx_data;
            end else if (pending && bus.tx_data !== held) begin
                unstable = 1;
            end
            if (bus.tx_done && pending) begin
                pending = 0;
                last_done = cyc;
                chk_eq("tx_data_stable", unstable, 0);
                unstable = 0;
                if (end_start && eb.size() == 0) begin
                    start = 1'b1;
                    first_addr = 8'd5;
                    last_addr  = 8'd5;
                end
            end
            if (done) begin
                done_seen = 1;
                chk_eq("done_latency", cyc - last_done, 1);
                chk_eq("busy_at_done", busy, 1);
            end
        end
        start = 1'b0;
        chk_eq("done_seen", done_seen, 1);
        chk_eq("byte_count", nsent, total);
        @(negedge clk);
        chk_eq("busy_fall", busy, 0);
        repeat (8) begin
            @(negedge clk);
            if (bus.tx_start || busy || done) extra++;
        end
        chk_eq("idle_after_done", extra, 0);
    endtask

    task automatic reset_mid();
        int seen, cyc, bad;
        seen = 0; cyc = 0; bad = 0;
        tx_delay = 20;
        start = 1'b1;
        first_addr = 8'h80;
        last_addr  = 8'h83;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (seen < NB + 1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (bus.tx_start) seen++;
        end
        chk_eq("rst_reach_word1", seen, NB + 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_eq("rst_mid_mem_addr", bus.mem_addr, 0);
        chk_eq("rst_mid_tx_start", bus.tx_start, 0);
        chk_eq("rst_mid_tx_data", bus.tx_data, 0);
        chk_eq("rst_mid_busy", busy, 0);
        chk_eq("rst_mid_done", done, 0);
        repeat (3) begin
            @(negedge clk);
            if (done || bus.tx_start || busy) bad++;
        end
        reset = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done || bus.tx_start || busy) bad++;
        end
        chk_eq("rst_no_resume", bad, 0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_mem_addr", bus.mem_addr, 0);
        chk_eq("rst_tx_start", bus.tx_start, 0);
        chk_eq("rst_tx_data", bus.tx_data, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        mem[3] = 32'h11223344;
        run_dump(8'd3, 8'd3, 3, 0, 0, 0);
        mem[0] = 32'h03020100;
        mem[1] = 32'h07060504;
        mem[2] = 32'h0B0A0908;
        run_dump(8'd0, 8'd2, 1, 0, 0, 0);
        run_dump(8'hFE, 8'h01, 2, 0, 0, 0);
        run_dump(8'd20, 8'd23, 4, 1, 1, 0);
        run_dump(8'd40, 8'd40, 1000, 0, 0, 0);
        reset_mid();
        run_dump(8'h90, 8'h91, 2, 0, 0, 0);
        run_dump(8'd60, 8'd61, 1, 0, 0, 1);
        for (int r = 0; r < 6; r++) begin
            logic [7:0] f;
            f = 8'($urandom);
            run_dump(f, 8'(int'(f) + int'($urandom_range(0, 5))), int'($urandom_range(1, 6)),
                     bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
